// File: rtl/cnna_acc_requant.sv
// cnna_acc_requant: accumulates groups of unsigned multiplier products into a
// saturating accumulator, then requantizes each group sum with a round-half-up
// right shift and unsigned saturation. The result sits in a registered
// valid/ready output stage.
module cnna_acc_requant #(
  parameter int PROD_W  = 35,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
  output logic [CNT_W-1:0]   out_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               load;
  logic [ACC_W:0]     acc_base;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               ovf_final;
  logic [CNT_W-1:0]   cnt_final;
  logic [ACC_W:0]     round_add;
  logic [ACC_W:0]     r_wide;
  logic               clip;
  logic [OUT_W-1:0]   data_q;

  // The output stage can take a new result when it is empty or being drained;
  // this depends only on registered state and out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && in_last;

  // Next-state logic: a group opens on a non-last beat and closes on its last beat.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (in_last) begin
        state_next = IDLE;
      end else begin
        state_next = ACCUM;
      end
    end
  end

  // Accumulate the current beat; a fresh group starts from zero so no clear cycle is needed.
  always_comb begin
    acc_base  = (state == IDLE) ? '0 : {1'b0, acc};
    sum_wide  = acc_base + {{(ACC_W + 1 - PROD_W){1'b0}}, in_data};
    sum_sat   = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    ovf_final = sum_wide[ACC_W] || ((state == ACCUM) && ovf);
    if (state == IDLE) begin
      cnt_final = CNT_W'(1);
    end else if (&cnt) begin
      cnt_final = cnt;
    end else begin
      cnt_final = cnt + CNT_W'(1);
    end
  end

  // Requantize: add half an output LSB, shift right, then clip to OUT_W bits.
  always_comb begin
    round_add = '0;
    if (shift != '0) begin
      round_add = {{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
    end
    r_wide = ({1'b0, sum_sat} + round_add) >> shift;
    if (shift >= SHIFT_W'(ACC_W)) begin
      r_wide = '0;
    end
    clip   = |r_wide[ACC_W:OUT_W];
    data_q = clip ? {OUT_W{1'b1}} : r_wide[OUT_W-1:0];
  end

  // Group state register; only advances on an accepted beat, so backpressure freezes it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc <= sum_sat;
        ovf <= ovf_final;
        cnt <= cnt_final;
      end
    end
  end

  // Output register: loads on the last beat, otherwise holds; valid drops when consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= data_q;
        out_sat   <= clip || ovf_final;
        out_cnt   <= cnt_final;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnna_acc_requant.sv
// Bench for cnna_acc_requant: directed table, hand-written corner sequences,
// and a randomized phase scored against an arithmetic reference model.
module tb_cnna_acc_requant;

  localparam longint unsigned PMAX = 64'h7_FFFF_FFFF;    // 2^35-1
  localparam longint unsigned AMAX = 64'hFF_FFFF_FFFF;   // 2^40-1

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [34:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [5:0]  shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] out_cnt;

  int n_pass = 0;
  int n_total = 0;
  bit rand_rdy = 1'b0;
  bit sb_en = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  cnna_acc_requant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_cnt(out_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int              n;
    longint unsigned b0, b1, b2;
    int              sh;
    int              exp_d;
    bit              exp_s;
    int              exp_c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  // Reference: sum with per-beat saturation, round-half-up shift, clip.
  function automatic logic [32:0] model(input longint unsigned beats[$], input int sh);
    longint unsigned acc = 0;
    longint unsigned r;
    bit ovf = 0;
    int n;
    foreach (beats[i]) begin
      acc = acc + beats[i];
      if (acc > AMAX) begin acc = AMAX; ovf = 1; end
    end
    if (sh >= 40) r = 0;
    else r = (acc + ((sh == 0) ? 64'd0 : (64'd1 << (sh - 1)))) >> sh;
    n = (beats.size() > 65535) ? 65535 : beats.size();
    return {((r > 65535) || ovf), 16'(n), ((r > 65535) ? 16'hFFFF : 16'(r))};
  endfunction

  // Present one beat (called at a negedge) and return at the negedge after acceptance.
  task automatic send_beat(input longint unsigned d, input bit last, input int sh);
    int t;
    in_valid = 1'b1; in_data = 35'(d); in_last = last; shift = 6'(sh);
    for (t = 0; t < 200; t++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (in_ready) break;
      @(negedge ap_clk);
    end
    if (t >= 200) begin
      n_total++;
      $display("FAIL beat_timeout got=in_ready_low want=accept");
    end
    @(negedge ap_clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  // Capture results at the moment they are handed off downstream.
  always @(negedge ap_clk) begin
    #2;
    if (sb_en && ap_rst_n && out_valid && out_ready)
      got_q.push_back({out_sat, out_cnt, out_data});
  end

  initial begin
    longint unsigned v;
    longint unsigned beats[$];
    int n, sh;

    tbl[0] = '{1, 1000, 0, 0, 3, 125, 0, 1};
    tbl[1] = '{3, 100, 200, 300, 2, 150, 0, 3};
    tbl[2] = '{1, 70000, 0, 0, 0, 65535, 1, 1};
    tbl[3] = '{33, PMAX, PMAX, PMAX, 24, 65535, 1, 33};
    tbl[4] = '{1, 5, 0, 0, 1, 3, 0, 1};
    tbl[5] = '{1, 4, 0, 0, 3, 1, 0, 1};
    tbl[6] = '{2, PMAX, PMAX, 0, 40, 0, 0, 2};
    tbl[7] = '{1, 65535, 0, 0, 0, 65535, 0, 1};
    tbl[8] = '{1, 131071, 0, 0, 1, 65535, 1, 1};
    tbl[9] = '{32, PMAX, PMAX, PMAX, 25, 32768, 0, 32};

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_cnt", out_cnt, 0);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Directed table, groups sent back to back with out_ready high
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < tbl[r].n; i++) begin
        v = (i == 0) ? tbl[r].b0 : ((i == 1) ? tbl[r].b1 : tbl[r].b2);
        send_beat(v, i == tbl[r].n - 1, tbl[r].sh);
        if (i < tbl[r].n - 1 && i < 3)
          chk($sformatf("row%0d_early_valid", r), out_valid, 0);
      end
      chk($sformatf("row%0d_valid", r), out_valid, 1);
      chk($sformatf("row%0d_data", r), out_data, 64'(tbl[r].exp_d));
      chk($sformatf("row%0d_sat", r), out_sat, 64'(tbl[r].exp_s));
      chk($sformatf("row%0d_cnt", r), out_cnt, 64'(tbl[r].exp_c));
    end

    // Backpressure: result 125 pending, downstream stalled, next beat waiting
    send_beat(1000, 1, 3);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 35'd5; in_last = 1'b1; shift = 6'd0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 125);
      chk("bp_out_cnt", out_cnt, 1);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge ap_clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 5);
    chk("bp_next_cnt", out_cnt, 1);
    @(negedge ap_clk);
    chk("bp_drained", out_valid, 0);

    // Reset in the middle of a group
    send_beat(50, 0, 1);
    send_beat(60, 0, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_cnt", out_cnt, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(negedge ap_clk);
    send_beat(8, 1, 1);
    chk("mrst_valid", out_valid, 1);
    chk("mrst_data", out_data, 4);
    chk("mrst_cnt", out_cnt, 1);
    chk("mrst_sat", out_sat, 0);
    @(negedge ap_clk);

    // Randomized groups with random downstream backpressure
    sb_en = 1'b1;
    rand_rdy = 1'b1;
    for (int g = 0; g < 60; g++) begin
      n = $urandom_range(1, 6);
      sh = $urandom_range(0, 45);
      beats.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) v = {$urandom(), $urandom()} & PMAX;
        else v = 64'($urandom_range(0, 4095));
        beats.push_back(v);
      end
      exp_q.push_back(model(beats, sh));
      foreach (beats[i]) send_beat(beats[i], i == n - 1, sh);
      if ($urandom_range(0, 3) == 0) @(negedge ap_clk);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) @(negedge ap_clk);
    sb_en = 1'b0;

    chk("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("sb%0d_data", i), got_q[i][15:0], exp_q[i][15:0]);
      chk($sformatf("sb%0d_cnt", i), got_q[i][31:16], exp_q[i][31:16]);
      chk($sformatf("sb%0d_sat", i), got_q[i][32], exp_q[i][32]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cnna_acc_requant.md
# cnna_acc_requant

Downstream consumer of the CNN datapath's 17×18 unsigned multiplier. It accumulates a group of 35-bit unsigned products into a saturating accumulator, then requantizes the sum with a round-half-up right shift and unsigned saturation. The result is presented on a registered valid/ready output for the feature-map writeback stage. One group of products (one output pixel/channel dot product) is delimited by `in_last`.

## Interface
- `PROD_W`, 35: product width; matches the multiplier's `dout`.
- `ACC_W`, 40: accumulator width; sum is unsigned.
- `OUT_W`, 16: requantized output width.
- `SHIFT_W`, 6: width of the shift control.
- `CNT_W`, 16: width of the group beat counter.

Ports:
- `ap_clk` in 1: single clock; all state changes on its rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_data` in PROD_W: unsigned product.
- `in_last` in 1: beat is the last of its group.
- `shift` in SHIFT_W: right-shift amount, sampled on the accepted last beat.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: downstream consumes the result.
- `out_data` out OUT_W: requantized result.
- `out_sat` out 1: result was clipped or the accumulator overflowed.
- `out_cnt` out CNT_W: number of beats in the group (saturates at all-ones).

## Operation
- Beat accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This rule applies uniformly to every beat, not only last beats.
- States:
  - IDLE: no open group.
  - ACCUM: group open.
- State transitions:
  - IDLE, accept with `!in_last` → ACCUM.
  - IDLE, accept with `in_last` → IDLE (single-beat group).
  - ACCUM, accept with `in_last` → IDLE.
  - Otherwise hold state.
- Accumulate on each accepted beat:
  - `sum = (state==IDLE ? 0 : acc) + in_data`, computed in ACC_W+1 bits.
  - If bit ACC_W is set, the accumulator saturates to 2^ACC_W−1 and sticky `ovf` is set.
  - `ovf` and the beat count restart on the first beat of each group.
- On the accepted last beat, requantize the beat's `sum` (after saturation):
  - `r = (sum + (shift==0 ? 0 : 2^(shift−1))) >> shift`, computed in ACC_W+1 bits.
  - If `shift ≥ ACC_W`, `r = 0`.
  - `out_data = min(r, 2^OUT_W−1)`.
  - `out_sat = (r > 2^OUT_W−1) || ovf_final`.
  - `out_cnt` = beat count including the last beat.
  - `out_valid` is set.
- `out_valid` clears on `out_valid && out_ready` unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- Output registers change only on load. They hold their values while `out_valid && !out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_sat`=0, `out_cnt`=0; state IDLE, `acc`=0, `ovf`=0, count=0.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle, including back-to-back single-beat groups while `out_ready`=1.
- Backpressure: while `out_valid && !out_ready`, `in_ready`=0 and all internal state is frozen.
- Reset asserted mid-group: the open group is discarded and any pending result is dropped. Output after reset matches the reset values.
- `shift`, `in_data`, and `in_last` are don't-care when no beat is accepted.
- No combinational path from `in_valid` to `in_ready`. `in_ready` depends only on `out_valid` and `out_ready`.

## Test plan
- Single beat 1000, `in_last`=1, `shift`=3 → next cycle: `out_valid`=1, `out_data`=125, `out_sat`=0, `out_cnt`=1.
- Group of beats 100, 200, 300 (last), `shift`=2 → `out_data`=150, `out_cnt`=3; `out_valid` appears only after the third beat.
- Single beat 70000, `shift`=0 → `out_data`=65535, `out_sat`=1.
- 33 beats of 2^35−1, `shift`=24 → accumulator saturates to 2^40−1; `out_data`=65535, `out_sat`=1, `out_cnt`=33.
- Backpressure:
  - Setup: hold `out_ready`=0 with a result pending and `in_valid`=1.
  - Expected while stalled: `in_ready`=0, outputs stable, no beats lost.
  - Then raise `out_ready` and send a next group of 5 (last) with `shift`=0.
  - Expected: next result `out_data`=5, with no bubble beyond one cycle.
- Assert `ap_rst_n` low after 2 beats of a group, release, then send single beat 8 with `shift`=1 → `out_data`=4, `out_cnt`=1, `out_sat`=0.
